// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port 32 KB video RAM shared by scan-out,
// the 68000 bus and a screen-fill engine, one access per clock.
module vram_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int FILL_LAST = 32767
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-2:0] cpu_addr,
  input  logic              cpu_uds,
  input  logic              cpu_lds,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [7:0]        fill_value,
  output logic              fill_busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_DONE, S_REL
  } state_t;

  typedef enum logic [1:0] {
    K_NONE, K_VID, K_HI, K_LO
  } kind_t;

  logic [7:0]        r_mem [2**ADDR_W];
  logic [7:0]        r_rd;
  kind_t             r_kind;
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-2:0] r_cpu_addr;
  logic              r_we;
  logic              r_lds;
  logic [15:0]       r_din;
  logic [7:0]        r_dhi;
  logic [7:0]        r_dlo;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [7:0]        r_fill_val;

  logic              w_vid_go;
  logic              w_cpu_slot;
  logic              w_cpu_go;
  logic              w_fill_go;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_we;
  logic              w_re;
  kind_t             w_kind;

  // Reset suppresses every slot so nothing is written on the reset edge
  assign w_vid_go   = !reset && (vid_addr != r_last);
  assign w_cpu_slot = (r_state == S_HI) || (r_state == S_LO);
  assign w_cpu_go   = !reset && w_cpu_slot && !w_vid_go;
  assign w_fill_go  = !reset && fill_busy
                      && !w_vid_go && !w_cpu_slot;
  assign w_accept   = cpu_req && !fill_busy && !fill_start;

  always_comb begin
    w_addr  = r_fill_cnt;
    w_wdata = r_fill_val;
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_kind  = K_NONE;
    unique case (1'b1)
      w_vid_go: begin
        w_addr = vid_addr;
        w_re   = 1'b1;
        w_kind = K_VID;
      end
      w_cpu_go: begin
        w_addr = {r_cpu_addr, r_state == S_LO};
        w_we   = r_we;
        w_re   = !r_we;
        if (r_state == S_HI) begin
          w_wdata = r_din[15:8];
          if (!r_we) w_kind = K_HI;
        end else begin
          w_wdata = r_din[7:0];
          if (!r_we) w_kind = K_LO;
        end
      end
      w_fill_go: w_we = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept) begin
          if (cpu_uds)      w_next = S_HI;
          else if (cpu_lds) w_next = S_LO;
          else              w_next = S_DONE;
        end
      S_HI:
        if (w_cpu_go) w_next = r_lds ? S_LO : S_DONE;
      S_LO:
        if (w_cpu_go) w_next = S_DONE;
      S_DONE: w_next = S_REL;
      S_REL:
        if (!cpu_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
    if (w_re) r_rd <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_kind     <= K_NONE;
      r_last     <= '0;
      r_cpu_addr <= '0;
      r_we       <= 1'b0;
      r_lds      <= 1'b0;
      r_din      <= '0;
      r_dhi      <= '0;
      r_dlo      <= '0;
      r_fill_cnt <= '0;
      r_fill_val <= '0;
      vid_dout   <= '0;
      cpu_dout   <= '0;
      cpu_ack    <= 1'b0;
      fill_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_kind  <= w_kind;
      cpu_ack <= (r_state == S_DONE);
      if (w_vid_go) r_last <= vid_addr;
      if (r_state == S_IDLE && w_accept) begin
        r_cpu_addr <= cpu_addr;
        r_we       <= cpu_we;
        r_lds      <= cpu_lds;
        r_din      <= cpu_din;
        r_dhi      <= '0;
        r_dlo      <= '0;
      end
      // Read bytes land one clock after their slot
      if (r_kind == K_VID) vid_dout <= r_rd;
      if (r_kind == K_HI)  r_dhi <= r_rd;
      if (r_kind == K_LO)  r_dlo <= r_rd;
      if (r_state == S_DONE)
        cpu_dout <= {(r_kind == K_HI) ? r_rd : r_dhi,
                     (r_kind == K_LO) ? r_rd : r_dlo};
      if (fill_start && !fill_busy) begin
        fill_busy  <= 1'b1;
        r_fill_cnt <= '0;
        r_fill_val <= fill_value;
      end else if (w_fill_go) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (r_fill_cnt == ADDR_W'(FILL_LAST)) fill_busy <= 1'b0;
      end
    end
  end
endmodule
